// File: rtl/ifft_but_stream_if.sv
// ---------------------------------------------------------------------------
// ifft_but_stream_if
// Streaming channel bundle for the radix-4 inverse butterfly.
// Input channel : iVALID, oREADY, iRE, iIM   (sample X0..X3 into the block)
// Output channel: oVALID, iREADY, oRE, oIM, oIDX, oLAST (Y0..Y3 out)
// Names follow the block's point of view: i* are driven by the environment,
// o* are driven by the butterfly.
// Modports: slave  = the butterfly itself
//           master = the surrounding environment (source and sink)
// ---------------------------------------------------------------------------
interface ifft_but_stream_if #(
  parameter int BIT = 17
);
  logic           iVALID;
  logic           oREADY;
  logic [BIT-1:0] iRE;
  logic [BIT-1:0] iIM;
  logic           oVALID;
  logic           iREADY;
  logic [BIT-1:0] oRE;
  logic [BIT-1:0] oIM;
  logic [1:0]     oIDX;
  logic           oLAST;

  modport slave (
    input  iVALID, iRE, iIM, iREADY,
    output oREADY, oVALID, oRE, oIM, oIDX, oLAST
  );

  modport master (
    output iVALID, iRE, iIM, iREADY,
    input  oREADY, oVALID, oRE, oIM, oIDX, oLAST
  );
endinterface

// File: rtl/ifft_but_stream.sv
// ---------------------------------------------------------------------------
// ifft_but_stream
// Streaming radix-4 inverse butterfly. Four complex samples are collected one
// per beat, the unscaled inverse DFT-4 is computed in one transfer cycle, and
// Y0..Y3 are emitted one per beat. Input and output buffers are independent,
// so a new frame can be collected while the previous one drains.
//
// Ports:
//   iCLK    clock
//   iRESET  synchronous active-high reset
//   bus     ifft_but_stream_if.slave (input and output valid/ready channels)
//   oOVF    sticky overflow flag
//
// Configuration:
//   IFFT_BUT_SAT_EN  defined  : results saturate to BIT bits, oOVF records clips
//                    undefined: results wrap to the low BIT bits, oOVF stays 0
// ---------------------------------------------------------------------------
module ifft_but_stream #(
  parameter int BIT = 17
) (
  input  logic                iCLK,
  input  logic                iRESET,
  ifft_but_stream_if.slave    bus,
  output logic                oOVF
);

  localparam int W = BIT + 2;

`ifdef IFFT_BUT_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  // Result does not fit in BIT bits when the three top bits disagree.
  function automatic logic clip_fn(input logic signed [W-1:0] v);
    return !((v[W-1:BIT-1] == 3'b000) || (v[W-1:BIT-1] == 3'b111));
  endfunction

  // Reduce a BIT+2 result to BIT bits: clamp when saturating, else wrap.
  function automatic logic [BIT-1:0] reduce_fn(input logic signed [W-1:0] v,
                                               input logic sat);
    logic [BIT-1:0] res;
    if (sat && clip_fn(v)) begin
      if (v[W-1]) begin
        res = {1'b1, {(BIT-1){1'b0}}};
      end else begin
        res = {1'b0, {(BIT-1){1'b1}}};
      end
    end else begin
      res = v[BIT-1:0];
    end
    return res;
  endfunction

  // State
  logic [2:0]     in_cnt_r;
  logic           ready_r;
  logic [BIT-1:0] x_re_r [4];
  logic [BIT-1:0] x_im_r [4];
  logic [BIT-1:0] y_re_r [4];
  logic [BIT-1:0] y_im_r [4];
  logic           out_busy_r;
  logic [1:0]     out_cnt_r;
  logic           last_r;
  logic           ovf_r;

  // Combinational helpers
  logic                 in_hs_s;
  logic                 out_hs_s;
  logic                 xfer_s;
  logic [2:0]           in_cnt_s;
  logic signed [W-1:0]  a_re_s [4];
  logic signed [W-1:0]  a_im_s [4];
  logic signed [W-1:0]  r_re_s [4];
  logic signed [W-1:0]  r_im_s [4];
  logic [BIT-1:0]       q_re_s [4];
  logic [BIT-1:0]       q_im_s [4];
  logic                 clip_s;

  // Handshakes, transfer condition and next input count.
  always_comb begin
    in_hs_s  = bus.iVALID & ready_r;
    out_hs_s = out_busy_r & bus.iREADY;
    // Output buffer is free when idle or when Y3 leaves at this very edge.
    xfer_s   = (in_cnt_r == 3'd4) & (~out_busy_r | (out_hs_s & last_r));
    if (xfer_s) begin
      in_cnt_s = 3'd0;
    end else if (in_hs_s) begin
      in_cnt_s = in_cnt_r + 3'd1;
    end else begin
      in_cnt_s = in_cnt_r;
    end
  end

  // Inverse DFT-4 on sign-extended inputs, then reduction to BIT bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a_re_s[i] = signed'({{2{x_re_r[i][BIT-1]}}, x_re_r[i]});
      a_im_s[i] = signed'({{2{x_im_r[i][BIT-1]}}, x_im_r[i]});
    end
    r_re_s[0] = a_re_s[0] + a_re_s[1] + a_re_s[2] + a_re_s[3];
    r_im_s[0] = a_im_s[0] + a_im_s[1] + a_im_s[2] + a_im_s[3];
    // Y1 = x0 + j*x1 - x2 - j*x3
    r_re_s[1] = a_re_s[0] - a_im_s[1] - a_re_s[2] + a_im_s[3];
    r_im_s[1] = a_im_s[0] + a_re_s[1] - a_im_s[2] - a_re_s[3];
    r_re_s[2] = a_re_s[0] - a_re_s[1] + a_re_s[2] - a_re_s[3];
    r_im_s[2] = a_im_s[0] - a_im_s[1] + a_im_s[2] - a_im_s[3];
    // Y3 = x0 - j*x1 - x2 + j*x3
    r_re_s[3] = a_re_s[0] + a_im_s[1] - a_re_s[2] - a_im_s[3];
    r_im_s[3] = a_im_s[0] - a_re_s[1] - a_im_s[2] + a_re_s[3];
    clip_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q_re_s[i] = reduce_fn(r_re_s[i], SAT_EN);
      q_im_s[i] = reduce_fn(r_im_s[i], SAT_EN);
      clip_s    = clip_s | clip_fn(r_re_s[i]) | clip_fn(r_im_s[i]);
    end
  end

  // Input collection, transfer into the output shift buffer, and emission.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      in_cnt_r   <= 3'd0;
      ready_r    <= 1'b1;
      out_busy_r <= 1'b0;
      out_cnt_r  <= 2'd0;
      last_r     <= 1'b0;
      ovf_r      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_re_r[i] <= {BIT{1'b0}};
        x_im_r[i] <= {BIT{1'b0}};
        y_re_r[i] <= {BIT{1'b0}};
        y_im_r[i] <= {BIT{1'b0}};
      end
    end else begin
      in_cnt_r <= in_cnt_s;
      ready_r  <= (in_cnt_s != 3'd4);
      if (in_hs_s) begin
        x_re_r[in_cnt_r[1:0]] <= bus.iRE;
        x_im_r[in_cnt_r[1:0]] <= bus.iIM;
      end
      if (xfer_s) begin
        for (int i = 0; i < 4; i++) begin
          y_re_r[i] <= q_re_s[i];
          y_im_r[i] <= q_im_s[i];
        end
        out_busy_r <= 1'b1;
        out_cnt_r  <= 2'd0;
        last_r     <= 1'b0;
        ovf_r      <= ovf_r | (SAT_EN & clip_s);
      end else if (out_hs_s) begin
        // Shift so the current sample always sits in slot 0; zeros fill in.
        for (int i = 0; i < 3; i++) begin
          y_re_r[i] <= y_re_r[i+1];
          y_im_r[i] <= y_im_r[i+1];
        end
        y_re_r[3]  <= {BIT{1'b0}};
        y_im_r[3]  <= {BIT{1'b0}};
        out_cnt_r  <= out_cnt_r + 2'd1;
        last_r     <= (out_cnt_r == 2'd2);
        out_busy_r <= ~last_r;
      end
    end
  end

  assign bus.oREADY = ready_r;
  assign bus.oVALID = out_busy_r;
  assign bus.oRE    = y_re_r[0];
  assign bus.oIM    = y_im_r[0];
  assign bus.oIDX   = out_cnt_r;
  assign bus.oLAST  = last_r;
  assign oOVF       = ovf_r;

endmodule

// File: tb/tb_ifft_but_stream.sv
// ---------------------------------------------------------------------------
// tb_ifft_but_stream
// Self-checking bench for ifft_but_stream. A monitor records every accepted
// input sample; each complete frame is turned into expected Y0..Y3 by a direct
// complex inverse DFT-4 (sum of x[n] * j^(n*k)) and queued. Every output
// handshake is compared against that queue. Directed scenarios cover reset,
// impulses, overflow, backpressure, reset mid-emit and continuous streaming;
// a random phase follows.
// ---------------------------------------------------------------------------
module tb_ifft_but_stream;
  localparam int BIT = 17;
  localparam int LIM = 1 << (BIT - 1);

`ifdef IFFT_BUT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic iCLK = 1'b0;
  logic iRESET;
  logic oOVF;

  ifft_but_stream_if #(.BIT(BIT)) bus ();

  ifft_but_stream #(.BIT(BIT)) dut (
    .iCLK   (iCLK),
    .iRESET (iRESET),
    .bus    (bus),
    .oOVF   (oOVF)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    int re;
    int im;
    int idx;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   fr_re[$];
  int   fr_im[$];
  bit   ovf_m = 1'b0;
  int   out_beats = 0;
  int   ready_low = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reduce a full-precision result to BIT bits (clamp or wrap).
  function automatic int reduce(input int v, output bit clip);
    logic signed [BIT-1:0] t;
    clip = (v > LIM - 1) || (v < -LIM);
    if (SAT && clip) return (v > 0) ? (LIM - 1) : -LIM;
    t = v[BIT-1:0];
    return int'(t);
  endfunction

  // Expected Y0..Y3 for the four collected samples.
  task automatic model_frame();
    int  yr[4];
    int  yi[4];
    int  sr, si, m;
    bit  c, any;
    exp_t e;
    any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        m = (n * k) % 4;
        case (m)
          0: begin sr += fr_re[n]; si += fr_im[n]; end
          1: begin sr -= fr_im[n]; si += fr_re[n]; end
          2: begin sr -= fr_re[n]; si -= fr_im[n]; end
          3: begin sr += fr_im[n]; si -= fr_re[n]; end
          default: begin end
        endcase
      end
      yr[k] = reduce(sr, c);
      any |= c;
      yi[k] = reduce(si, c);
      any |= c;
    end
    ovf_m = ovf_m | (SAT & any);
    for (int k = 0; k < 4; k++) begin
      e.re  = yr[k];
      e.im  = yi[k];
      e.idx = k;
      e.ovf = int'(ovf_m);
      exp_q.push_back(e);
    end
    fr_re.delete();
    fr_im.delete();
  endtask

  // Monitor: checks outputs and feeds the model, sampled mid-cycle.
  always @(negedge iCLK) begin
    if (iRESET) begin
      exp_q.delete();
      fr_re.delete();
      fr_im.delete();
      ovf_m = 1'b0;
    end else begin
      if (!bus.oREADY) ready_low++;
      if (bus.oVALID && bus.iREADY) begin
        out_beats++;
        check_eq("out_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check_eq("y_re", int'($signed(bus.oRE)), mon_e.re);
          check_eq("y_im", int'($signed(bus.oIM)), mon_e.im);
          check_eq("y_idx", int'(bus.oIDX), mon_e.idx);
          check_eq("y_last", int'(bus.oLAST), int'(mon_e.idx == 3));
          check_eq("y_ovf", int'(oOVF), mon_e.ovf);
        end
      end
      if (bus.iVALID && bus.oREADY) begin
        fr_re.push_back(int'($signed(bus.iRE)));
        fr_im.push_back(int'($signed(bus.iIM)));
        if (fr_re.size() == 4) model_frame();
      end
    end
  end

  // Drive one sample and hold it until accepted (bounded).
  task automatic send(input int re, input int im);
    int g;
    bit acc;
    g = 0;
    acc = 1'b0;
    bus.iVALID = 1'b1;
    bus.iRE    = re[BIT-1:0];
    bus.iIM    = im[BIT-1:0];
    while (!acc && g < 50) begin
      @(negedge iCLK);
      acc = bus.oREADY;
      @(posedge iCLK);
      #1;
      g++;
    end
    if (!acc) check_eq("send_timeout", 0, 1);
    bus.iVALID = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge iCLK);
      #1;
      g++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  function automatic int rnd_word();
    return int'($urandom_range(0, 2 * LIM - 1)) - LIM;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int beats0, g, lowc, nb, rl0;
    iRESET     = 1'b1;
    bus.iVALID = 1'b0;
    bus.iRE    = '0;
    bus.iIM    = '0;
    bus.iREADY = 1'b1;
    repeat (2) @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    @(negedge iCLK);
    check_eq("rst_valid", int'(bus.oVALID), 0);
    check_eq("rst_ready", int'(bus.oREADY), 1);
    check_eq("rst_re", int'($signed(bus.oRE)), 0);
    check_eq("rst_im", int'($signed(bus.oIM)), 0);
    check_eq("rst_idx", int'(bus.oIDX), 0);
    check_eq("rst_last", int'(bus.oLAST), 0);
    check_eq("rst_ovf", int'(oOVF), 0);
    @(posedge iCLK);
    #1;

    // Impulse at X0, with latency check.
    send(4, 0); send(0, 0); send(0, 0); send(0, 0);
    @(negedge iCLK);
    check_eq("lat_e0_valid", int'(bus.oVALID), 0);
    check_eq("lat_e0_ready", int'(bus.oREADY), 0);
    @(negedge iCLK);
    check_eq("lat_y0_valid", int'(bus.oVALID), 1);
    check_eq("lat_y0_idx", int'(bus.oIDX), 0);
    drain();

    // Impulse at X1.
    send(0, 0); send(1, 0); send(0, 0); send(0, 0);
    drain();

    // Overflow frame.
    repeat (4) send(LIM - 1, 0);
    drain();
    check_eq("ovf_sticky", int'(oOVF), int'(SAT));

    // Reset one cycle after the Y1 handshake.
    beats0 = out_beats;
    send(7, 1); send(2, 3); send(-5, 9); send(100, -4);
    g = 0;
    while (out_beats < beats0 + 2 && g < 50) begin
      @(posedge iCLK);
      g++;
    end
    check_eq("rst_wait", int'(g < 50), 1);
    #1;
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    @(negedge iCLK);
    check_eq("mid_rst_valid", int'(bus.oVALID), 0);
    check_eq("mid_rst_ready", int'(bus.oREADY), 1);
    check_eq("mid_rst_ovf", int'(oOVF), 0);
    @(posedge iCLK);
    #1;
    send(2, 0); send(0, 0); send(0, 0); send(0, 0);
    drain();

    // Backpressure: frame A held in output, frame B fills input.
    bus.iREADY = 1'b0;
    for (int i = 0; i < 8; i++) send(rnd_word(), rnd_word());
    lowc = 0;
    repeat (5) begin
      @(negedge iCLK);
      if (!bus.oREADY) lowc++;
    end
    check_eq("bp_ready_low", lowc, 5);
    check_eq("bp_hold_valid", int'(bus.oVALID), 1);
    check_eq("bp_hold_idx", int'(bus.oIDX), 0);
    @(posedge iCLK);
    #1;
    bus.iREADY = 1'b1;
    nb = 0;
    repeat (8) begin
      @(negedge iCLK);
      if (bus.oVALID) nb++;
    end
    check_eq("bp_no_bubble", nb, 8);
    drain();

    // Continuous stream of four frames.
    rl0 = ready_low;
    for (int i = 0; i < 16; i++) send(rnd_word(), rnd_word());
    check_eq("stream_ready_low", ready_low - rl0, 3);
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      bus.iVALID = ($urandom_range(0, 9) < 7);
      bus.iRE    = BIT'($urandom);
      bus.iIM    = BIT'($urandom);
      bus.iREADY = ($urandom_range(0, 9) < 7);
      @(posedge iCLK);
      #1;
    end
    bus.iVALID = 1'b0;
    bus.iREADY = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ifft_but_stream.md
Name: ifft_but_stream

Overview:
Streaming radix-4 inverse butterfly, the IFFT counterpart of the team's forward radix-4 butterfly. It collects four complex samples (X0..X3) one per beat over a valid/ready input channel. It computes the unscaled inverse DFT-4 in a single transfer cycle. It emits Y0..Y3 one per beat over a valid/ready output channel. The input and output buffers are independent, so the next frame can be collected while the current frame drains.

Parameters:
BIT, 17, width of the input and output real/imag words (signed two's complement).

Ports:
iCLK  in  1  clock.
iRESET  in  1  synchronous, active-high reset.
iVALID  in  1  input sample valid.
oREADY  out  1  block can accept an input sample.
iRE  in  BIT  input sample, real part.
iIM  in  BIT  input sample, imaginary part.
oVALID  out  1  output sample valid.
iREADY  in  1  downstream accepts the output sample.
oRE  out  BIT  output sample, real part.
oIM  out  BIT  output sample, imaginary part.
oIDX  out  2  index of the current output sample (0..3).
oLAST  out  1  high with Y3 (oIDX==3).
oOVF  out  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Reset (iRESET=1 at a rising edge):
  - in_cnt=0, out_busy=0, out_cnt=0, oOVF=0.
  - All buffers cleared to 0.
  - Resulting outputs: oVALID=0, oREADY=1, oRE=oIM=0, oIDX=0, oLAST=0.
  - Reset mid-frame or mid-emit discards all partial or pending data; the next accepted sample is X0 of a fresh frame.
- Input side:
  - oREADY = (in_cnt<4).
  - On iVALID&oREADY, store the sample into x[in_cnt] and increment in_cnt.
  - in_cnt==4 means the input buffer is full.
- Transfer:
  - Occurs at the edge where in_cnt==4 and the output buffer is free. Free means out_busy==0, or the Y3 handshake (oVALID&iREADY&oLAST) occurs at that same edge.
  - On transfer: load y[0..3], set out_busy=1, out_cnt=0, in_cnt=0.
  - No sample is accepted during the transfer cycle, because oREADY=0 while in_cnt==4.
- Arithmetic: sign-extend inputs to BIT+2 bits, no rounding, no scaling.
  - Y0 = x0+x1+x2+x3.
  - Y1: re = x0re - x1im - x2re + x3im; im = x0im + x1re - x2im - x3re.
  - Y2 = x0-x1+x2-x3.
  - Y3: re = x0re + x1im - x2re - x3im; im = x0im - x1re - x2im + x3re.
  - Result reduction from BIT+2 to BIT is defined under Optional Feature.
- Output side:
  - oVALID = out_busy.
  - oRE/oIM = y[out_cnt]; oIDX = out_cnt; oLAST = (out_cnt==3).
  - Outputs are held stable while oVALID&!iREADY.
  - On oVALID&iREADY: out_cnt increments; after Y3, out_busy=0 unless a transfer loads a new frame at the same edge.
- Latency: the edge that accepts X3 is E0. Transfer happens at E1 if the output buffer is free. Y0 is presented in the cycle after E1.
- Throughput: 5 cycles per frame on the input side; 4 output beats per 5 cycles at full rate.
- Simultaneous events: with the input full, a Y3 handshake and the transfer take place at the same edge with no bubble. A stalled output holds in_cnt at 4 and oREADY at 0 indefinitely without data loss.

Optional Feature:
Macro IFFT_BUT_SAT_EN.
- Defined:
  - Each BIT+2 result is saturated to [-2^(BIT-1), 2^(BIT-1)-1] at transfer.
  - oOVF sets to 1 if any of the 8 components clipped, and holds until reset.
- Undefined:
  - Results are truncated to the low BIT bits (wrap).
  - oOVF is tied to 0.

Test Plan:
- Impulse at X0: frame x0=(4,0), x1..x3=(0,0) -> Y0..Y3 all (4,0); oIDX 0,1,2,3; oLAST only on Y3; Y0 in the cycle after the transfer edge.
- Impulse at X1: x1=(1,0), others 0 -> Y0=(1,0), Y1=(0,1), Y2=(-1,0), Y3=(0,-1).
- Overflow, BIT=17: all four inputs (65535,0).
  - With IFFT_BUT_SAT_EN: Y0=(65535,0) and oOVF=1 sticky; Y1..Y3=(0,0).
  - Without the macro: Y0 re=-4, oOVF=0.
- Backpressure: iREADY=0 after frame A loads; stream frame B -> oREADY drops after 4 beats. Release iREADY -> A emitted intact, B transferred at A's Y3 handshake edge, B emitted intact with no bubble.
- Reset mid-emit: iRESET=1 for one cycle after the Y1 handshake -> next cycle oVALID=0, oREADY=1, oOVF=0; the following frame (2,0),(0,0),(0,0),(0,0) yields four (2,0) outputs.
- Continuous stream, iREADY=1: 4 back-to-back frames -> 16 correct outputs, oREADY low exactly 1 cycle per frame, no lost or duplicated samples.
